// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
// Optional: define MULDIV_EARLY_OUT_EN to let multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int XLEN = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              signA_q, signA_d, signB_q, signB_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              aSignedIn, bSignedIn, signAIn, signBIn, divZeroIn, ovfIn;
    logic [XLEN-1:0]   absAIn, absBIn, specialRes;
    logic [XLEN:0]     divShift;
    logic [XLEN-1:0]   divTrial;
    logic              divGe, calcLast;
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0]   quoFix, remFix, fixRes;

    // Decode of an incoming request: operand signs, magnitudes and the results of the bypass cases.
    always_comb begin
        aSignedIn  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        bSignedIn  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        signAIn    = aSignedIn && rs1_data[XLEN-1];
        signBIn    = bSignedIn && rs2_data[XLEN-1];
        absAIn     = signAIn ? -rs1_data : rs1_data;
        absBIn     = signBIn ? -rs2_data : rs2_data;
        divZeroIn  = funct3[2] && (rs2_data == '0);
        ovfIn      = funct3[2] && !funct3[0] && (rs1_data == INT_MIN) && (rs2_data == '1);
        specialRes = '0;
        if (divZeroIn) begin
            specialRes = funct3[1] ? rs1_data : '1;
        end else if (ovfIn) begin
            specialRes = funct3[1] ? '0 : rs1_data;
        end
    end

    // Restoring-divide step: the divisor lives in the low half of mcand, the dividend shifts out of mplier.
    always_comb begin
        divShift = {rem_q, mplier_q[XLEN-1]};
        divGe    = divShift >= {1'b0, mcand_q[XLEN-1:0]};
        divTrial = divShift[XLEN-1:0] - mcand_q[XLEN-1:0];
`ifdef MULDIV_EARLY_OUT_EN
        calcLast = (cnt_q == '0) || (!op_q[2] && (mplier_q[XLEN-1:1] == '0));
`else
        calcLast = (cnt_q == '0);
`endif
    end

    always_comb begin
        prodFix = (signA_q ^ signB_q) ? -acc_q : acc_q;
        quoFix  = (signA_q ^ signB_q) ? -mplier_q : mplier_q;
        remFix  = signA_q ? -rem_q : rem_q;
        case (op_q)
            3'b000:                 fixRes = prodFix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fixRes = prodFix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fixRes = quoFix;
            default:                fixRes = remFix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        signA_d  = signA_q;
        signB_d  = signB_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    op_d     = funct3;
                    signA_d  = signAIn;
                    signB_d  = signBIn;
                    cnt_d    = CNT_LAST;
                    acc_d    = '0;
                    rem_d    = '0;
                    mcand_d  = {{XLEN{1'b0}}, (funct3[2] ? absBIn : absAIn)};
                    mplier_d = funct3[2] ? absAIn : absBIn;
                    if (divZeroIn || ovfIn) begin
                        result_d = specialRes;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!op_q[2]) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    rem_d    = divGe ? divTrial : divShift[XLEN-1:0];
                    mplier_d = {mplier_q[XLEN-2:0], divGe};
                end
                if (calcLast) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_FIX: begin
                result_d = fixRes;
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A flush drops the operation without touching the visible result.
        if (kill && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            signA_q  <= 1'b0;
            signB_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            signA_q  <= signA_d;
            signB_q  <= signB_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes reference results, a negedge monitor pops them on done.
// Honours MULDIV_EARLY_OUT_EN by relaxing multiply latency to an upper bound.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    typedef struct {
        logic [XLEN-1:0] res;
        int              startCyc;
        int              lat;
        bit              exact;
    } expT;

    logic            clk;
    logic            rst;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    expT             expQ[$];
    expT             monItem;
    int              cyc = 0;
    int              checks = 0;
    int              failures = 0;
    int              doneCount = 0;
    int              busyTotal = 0;
    logic [XLEN-1:0] lastRes = '0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .kill     (kill),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference results straight from the RV32M arithmetic definitions.
    function automatic logic [XLEN-1:0] refModel(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        longint          sa = longint'(signed'(a));
        longint          sb = longint'(signed'(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [63:0]     p;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit isSpecial(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Monitor: every done must match the oldest outstanding expectation, in value and latency.
    always @(negedge clk) begin
        if (busy) busyTotal++;
        if (rst && done) begin
            doneCount++;
            checkOutput("busyLowInDone", 64'(busy), 64'(0));
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDone", 64'(done), 64'(0));
            end else begin
                monItem = expQ.pop_front();
                checkOutput("result", 64'(result), 64'(monItem.res));
                if (monItem.exact)
                    checkOutput("latency", 64'(cyc - monItem.startCyc), 64'(monItem.lat));
                else
                    checkOutput("latencyBound", 64'((cyc - monItem.startCyc) <= monItem.lat), 64'(1));
            end
        end
    end

    // Called just after a rising edge; start is sampled at the following edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit expectDone);
        expT e;
        funct3   = op;
        rs1_data = a;
        rs2_data = b;
        start    = 1'b1;
        if (expectDone) begin
            e.res      = refModel(op, a, b);
            e.startCyc = cyc;
            e.lat      = isSpecial(op, a, b) ? 1 : XLEN + 2;
            e.exact    = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            if (!op[2]) begin
                e.exact = 1'b0;
                if (b < 32'd4) e.lat = 5;
            end
`endif
            expQ.push_back(e);
            lastRes = e.res;
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
    endtask

    task automatic waitDone();
        int n;
        n = doneCount;
        for (int i = 0; i < 200; i++) begin
            if (doneCount > n) break;
            @(posedge clk);
            #1;
        end
        checkOutput("doneSeen", 64'(doneCount > n), 64'(1));
    endtask

    task automatic runOp(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        applyStimulus(op, a, b, 1'b1);
        waitDone();
    endtask

    initial begin
        int n;
        int b0;
        logic [2:0] op;
        logic [XLEN-1:0] a, b;

        rst = 1'b0; start = 1'b0; kill = 1'b0;
        funct3 = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetBusy", 64'(busy), 64'(0));
        checkOutput("resetDone", 64'(done), 64'(0));
        checkOutput("resetResult", 64'(result), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        b0 = busyTotal;
        runOp(3'd0, 32'd7, 32'hFFFFFFFD);
        checkOutput("mulBusyCycles", 64'(busyTotal - b0), 64'(33));

        runOp(3'd1, 32'h80000000, 32'h80000000);
        runOp(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runOp(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runOp(3'd4, 32'hFFFFFFF9, 32'd2);
        runOp(3'd6, 32'hFFFFFFF9, 32'd2);
        runOp(3'd5, 32'd100, 32'd7);
        runOp(3'd7, 32'd100, 32'd7);
        runOp(3'd4, 32'd5, 32'd0);
        runOp(3'd6, 32'd5, 32'd0);
        runOp(3'd4, 32'h80000000, 32'hFFFFFFFF);
        runOp(3'd6, 32'h80000000, 32'hFFFFFFFF);

        // Flush on the 10th CALC cycle.
        applyStimulus(3'd3, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        checkOutput("busyBeforeKill", 64'(busy), 64'(1));
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        checkOutput("busyAfterKill", 64'(busy), 64'(0));
        n = doneCount;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("noDoneAfterKill", 64'(doneCount), 64'(n));
        checkOutput("resultKeptAfterKill", 64'(result), 64'(lastRes));
        runOp(3'd5, 32'd100, 32'd7);

        // start and kill together in IDLE: nothing is accepted.
        funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        checkOutput("startKillIgnored", 64'(busy), 64'(0));

        // A start pulse mid-CALC must not disturb the running operation.
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        funct3 = 3'd4; rs1_data = 32'd5; rs2_data = 32'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone();

        // Asynchronous reset mid-CALC.
        applyStimulus(3'd1, 32'hDEADBEEF, 32'h01234567, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("asyncRstBusy", 64'(busy), 64'(0));
        checkOutput("asyncRstDone", 64'(done), 64'(0));
        checkOutput("asyncRstResult", 64'(result), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        lastRes = '0;
        @(posedge clk);
        #1;
        runOp(3'd0, 32'd3, 32'd2);

        // Randomised operations with occasional corner operands.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            runOp(op, a, b);
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("pendingExpectations", 64'(expQ.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
